// File: rtl/addsub_accum_if.sv
// ---------------------------------------------------------------------------
// addsub_accum_if
// Command and result handshake bundle for the addsub_accum stage.
//
// Signal names keep the stage's own point of view (suffix _i = into the
// stage, _o = out of the stage).
//   valid_i / ready_o           : command handshake (issue logic -> stage)
//   op_i, operand_i             : command payload
//   valid_o / ready_i           : result handshake (stage -> consumer)
//   result_o, carry_o,
//   overflow_o, zero_o,
//   sticky_ovf_o                : result payload
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The sender keeps valid and its
// payload stable until that edge; ready may depend combinationally on the
// receiver's downstream ready.
//
// Modports:
//   slave  : the accumulator stage itself
//   master : issue logic plus result consumer (the testbench)
// ---------------------------------------------------------------------------
interface addsub_accum_if #(
  parameter int BIT = 32
);
  logic           valid_i;
  logic           ready_o;
  logic [1:0]     op_i;
  logic [BIT-1:0] operand_i;
  logic           valid_o;
  logic           ready_i;
  logic [BIT-1:0] result_o;
  logic           carry_o;
  logic           overflow_o;
  logic           zero_o;
  logic           sticky_ovf_o;

  modport slave (
    input  valid_i, op_i, operand_i, ready_i,
    output ready_o, valid_o, result_o, carry_o, overflow_o, zero_o, sticky_ovf_o
  );

  modport master (
    output valid_i, op_i, operand_i, ready_i,
    input  ready_o, valid_o, result_o, carry_o, overflow_o, zero_o, sticky_ovf_o
  );
endinterface

// File: rtl/addsub_accum.sv
// ---------------------------------------------------------------------------
// addsub_accum
// Sequential accumulator stage. Takes one LOAD/ADD/SUB/CLR command per
// handshake, updates a BIT-wide accumulator and presents the result and
// flags through a one-entry valid/ready output register.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous reset, active-high
//   bus          : addsub_accum_if.slave (command + result handshakes)
//   o_dbg_state  : output stage state (0 = EMPTY, 1 = FULL)
//
// Ops: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
//
// Build option: define ADDSUB_ACCUM_SAT_EN for unsigned saturation (ADD
// with carry pins to all ones, SUB with borrow pins to zero). carry_o and
// overflow_o still report the unsaturated event. Without the macro results
// wrap modulo 2^BIT. Handshake and latency are the same in both builds.
// ---------------------------------------------------------------------------
module addsub_accum #(
  parameter int BIT = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  addsub_accum_if.slave      bus,
  output logic               o_dbg_state
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [BIT-1:0] r_acc;
  logic           r_carry;
  logic           r_ovf;
  logic           r_sticky;

  logic           w_accept;
  logic [BIT:0]   w_sum;
  logic [BIT:0]   w_diff;
  logic [BIT-1:0] w_acc_nxt;
  logic           w_carry_nxt;
  logic           w_ovf_nxt;
  logic           w_sticky_nxt;

  // -------------------------------------------------------------------------
  // Handshake. ready_o passes ready_i straight through when FULL so that a
  // result being taken frees the slot in the same cycle (1 cmd/cycle).
  // -------------------------------------------------------------------------
  assign bus.ready_o = (r_state == ST_EMPTY) || bus.ready_i;
  assign w_accept    = bus.valid_i && bus.ready_o;

  // -------------------------------------------------------------------------
  // Output stage FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        // Taken with nothing new behind it -> drain; taken with a new
        // command or not taken at all -> stay FULL.
        if (bus.ready_i && !w_accept) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // -------------------------------------------------------------------------
  // Arithmetic. Both paths are BIT+1 wide so the top bit is the carry out.
  // Subtraction is acc + ~b + 1; its carry out is the inverse of borrow.
  // -------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_acc} + {1'b0, bus.operand_i};
  assign w_diff = {1'b0, r_acc} + {1'b0, ~bus.operand_i} + {{BIT{1'b0}}, 1'b1};

  always_comb begin
    w_acc_nxt   = r_acc;
    w_carry_nxt = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (bus.op_i)
      OP_LOAD: begin
        w_acc_nxt = bus.operand_i;
      end
      OP_ADD: begin
        w_acc_nxt   = w_sum[BIT-1:0];
        w_carry_nxt = w_sum[BIT];
        // Same-sign operands producing a result of the other sign.
        w_ovf_nxt   = (r_acc[BIT-1] == bus.operand_i[BIT-1]) &&
                      (w_sum[BIT-1] != r_acc[BIT-1]);
`ifdef ADDSUB_ACCUM_SAT_EN
        if (w_sum[BIT]) w_acc_nxt = {BIT{1'b1}};
`endif
      end
      OP_SUB: begin
        w_acc_nxt   = w_diff[BIT-1:0];
        w_carry_nxt = ~w_diff[BIT];
        // Opposite-sign operands producing a result with the subtrahend's sign.
        w_ovf_nxt   = (r_acc[BIT-1] != bus.operand_i[BIT-1]) &&
                      (w_diff[BIT-1] != r_acc[BIT-1]);
`ifdef ADDSUB_ACCUM_SAT_EN
        if (!w_diff[BIT]) w_acc_nxt = {BIT{1'b0}};
`endif
      end
      OP_CLR: begin
        w_acc_nxt = {BIT{1'b0}};
      end
      default: begin
        w_acc_nxt = r_acc;
      end
    endcase
  end

  // CLR is the only thing that lowers sticky; otherwise any overflow sets it.
  assign w_sticky_nxt = (bus.op_i == OP_CLR) ? 1'b0 : (r_sticky | w_ovf_nxt);

  // -------------------------------------------------------------------------
  // Accumulator and result registers. The accumulator doubles as result_o,
  // so the two can never disagree. Everything moves only on accept, which
  // keeps the presented result stable while the consumer stalls.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc    <= {BIT{1'b0}};
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= w_acc_nxt;
      r_carry  <= w_carry_nxt;
      r_ovf    <= w_ovf_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign bus.valid_o      = (r_state == ST_FULL);
  assign bus.result_o     = r_acc;
  assign bus.carry_o      = r_carry;
  assign bus.overflow_o   = r_ovf;
  assign bus.zero_o       = (r_acc == {BIT{1'b0}});
  assign bus.sticky_ovf_o = r_sticky;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_addsub_accum.sv
// ---------------------------------------------------------------------------
// tb_addsub_accum
// Directed bench for addsub_accum at BIT=8. Expected values are worked out
// by hand from the arithmetic rules and written inline. Inputs change on
// the falling edge; outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_addsub_accum;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic clk;
  logic rst;
  logic dbg_state;
  int   checks;
  int   failures;

  addsub_accum_if #(.BIT(8)) bus ();

  addsub_accum #(.BIT(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One command with the consumer ready; returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] val);
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.op_i      = op;
    bus.operand_i = val;
    bus.ready_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i   = 1'b0;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.op_i        = OP_LOAD;
    bus.operand_i   = 8'h00;
    bus.ready_i     = 1'b1;

    // ---- reset state ----
    #1;
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_result", 32'(bus.result_o), 32'h00);
    check("rst_zero", 32'(bus.zero_o), 32'd1);
    check("rst_carry", 32'(bus.carry_o), 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);
    check("rst_sticky", 32'(bus.sticky_ovf_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- 1: async reset while FULL and stalled ----
    send(OP_LOAD, 8'h33);
    bus.ready_i = 1'b0;
    check("t1_full_valid", 32'(bus.valid_o), 32'd1);
    check("t1_full_result", 32'(bus.result_o), 32'h33);
    @(posedge clk);
    #2;
    check("t1_hold_result", 32'(bus.result_o), 32'h33);
    rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(bus.valid_o), 32'd0);
    check("t1_async_result", 32'(bus.result_o), 32'h00);
    check("t1_async_zero", 32'(bus.zero_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.ready_i = 1'b1;

    // ---- 2: ADD with carry out ----
    send(OP_LOAD, 8'hF0);
    send(OP_ADD, 8'h20);
`ifdef ADDSUB_ACCUM_SAT_EN
    check("t2_result", 32'(bus.result_o), 32'hFF);
`else
    check("t2_result", 32'(bus.result_o), 32'h10);
`endif
    check("t2_carry", 32'(bus.carry_o), 32'd1);
    check("t2_ovf", 32'(bus.overflow_o), 32'd0);
    check("t2_valid", 32'(bus.valid_o), 32'd1);

    // ---- 3: SUB with borrow ----
    send(OP_LOAD, 8'h05);
    check("t3_load_carry", 32'(bus.carry_o), 32'd0);
    send(OP_SUB, 8'h07);
`ifdef ADDSUB_ACCUM_SAT_EN
    check("t3_result", 32'(bus.result_o), 32'h00);
    check("t3_zero", 32'(bus.zero_o), 32'd1);
`else
    check("t3_result", 32'(bus.result_o), 32'hFE);
    check("t3_zero", 32'(bus.zero_o), 32'd0);
`endif
    check("t3_borrow", 32'(bus.carry_o), 32'd1);
    check("t3_ovf", 32'(bus.overflow_o), 32'd0);

    // ---- 4: signed overflow and sticky ----
    send(OP_LOAD, 8'h7F);
    send(OP_ADD, 8'h01);
    check("t4_result", 32'(bus.result_o), 32'h80);
    check("t4_ovf", 32'(bus.overflow_o), 32'd1);
    check("t4_carry", 32'(bus.carry_o), 32'd0);
    check("t4_sticky", 32'(bus.sticky_ovf_o), 32'd1);
    send(OP_ADD, 8'h00);
    check("t4_add0_ovf", 32'(bus.overflow_o), 32'd0);
    check("t4_add0_sticky", 32'(bus.sticky_ovf_o), 32'd1);
    send(OP_CLR, 8'h5A);
    check("t4_clr_result", 32'(bus.result_o), 32'h00);
    check("t4_clr_sticky", 32'(bus.sticky_ovf_o), 32'd0);
    check("t4_clr_zero", 32'(bus.zero_o), 32'd1);
    // SUB overflow: 0x80 - 0x01 = 0x7F (-128 - 1), no borrow
    send(OP_LOAD, 8'h80);
    send(OP_SUB, 8'h01);
    check("t4_sub_result", 32'(bus.result_o), 32'h7F);
    check("t4_sub_ovf", 32'(bus.overflow_o), 32'd1);
    check("t4_sub_borrow", 32'(bus.carry_o), 32'd0);
    check("t4_sub_sticky", 32'(bus.sticky_ovf_o), 32'd1);
    send(OP_CLR, 8'h00);
    check("t4_clr2_sticky", 32'(bus.sticky_ovf_o), 32'd0);

    // ---- 5: backpressure with a pending command ----
    send(OP_LOAD, 8'h10);
    bus.ready_i   = 1'b0;
    bus.valid_i   = 1'b1;
    bus.op_i      = OP_ADD;
    bus.operand_i = 8'h05;
    #1;
    check("t5_ready_low", 32'(bus.ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_stall_ready", 32'(bus.ready_o), 32'd0);
      check("t5_stall_result", 32'(bus.result_o), 32'h10);
      check("t5_stall_valid", 32'(bus.valid_o), 32'd1);
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    #1;
    check("t5_ready_high", 32'(bus.ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check("t5_new_result", 32'(bus.result_o), 32'h15);
    check("t5_new_valid", 32'(bus.valid_o), 32'd1);
    @(posedge clk);
    #1;
    check("t5_drain_valid", 32'(bus.valid_o), 32'd0);
    check("t5_no_dup", 32'(bus.result_o), 32'h15);
    check("t5_drain_state", 32'(dbg_state), 32'd0);

    // ---- 6: streaming ADD 0x01 x16 from 0x00 ----
    send(OP_CLR, 8'h00);
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.op_i      = OP_ADD;
    bus.operand_i = 8'h01;
    bus.ready_i   = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 16) bus.valid_i = 1'b0;
      check("t6_stream_result", 32'(bus.result_o), 32'(i));
      check("t6_stream_valid", 32'(bus.valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    check("t6_end_valid", 32'(bus.valid_o), 32'd0);
    check("t6_end_result", 32'(bus.result_o), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so a wedged run still ends with a report.
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
